rom_loader: RTL and testbench

ROM_LOADER -- requirements
Module: rom_loader

---
 rtl/rom_loader_pkg.sv | 16 +
 rtl/rom_loader_pow2_mask.sv | 25 ++
 rtl/rom_loader.sv | 141 ++++++++++++++
 tb/tb_rom_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared definitions for the cartridge ROM loader: FSM states and default
// selector/fill constants.
package rom_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_MASK,
        ST_DONE
    } state_t;

    localparam logic [7:0] DEFAULT_CART_INDEX = 8'h01;
    localparam logic [7:0] DEFAULT_FILL_VALUE = 8'hFF;

endpackage

// File: rtl/rom_loader_pow2_mask.sv
// Mirroring mask for a loaded image: (next power of two >= size) - 1,
// with sizes 0 and 1 both giving an all-zero mask.
module pow2_mask #(
    parameter int AW = 15
) (
    input  logic [AW:0]   size,
    output logic [AW-1:0] mask
);

    logic [AW-1:0] smear;

    always_comb begin
        // size == 2**AW has zero low bits, so size-1 wraps to all ones as required
        smear = size[AW-1:0] - AW'(1);
        for (int unsigned s = 1; s < AW; s = s * 2) begin
            smear = smear | (smear >> s);
        end
        if (size <= (AW+1)'(1)) begin
            mask = '0;
        end else begin
            mask = smear;
        end
    end

endmodule

// File: rtl/rom_loader.sv
// Streams a host download into cartridge RAM, pads the rest of the window
// with a fill byte and computes the mirroring mask for the loaded size.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int            AW         = 15,
    parameter int            DW         = 8,
    parameter logic [7:0]    CART_INDEX = DEFAULT_CART_INDEX,
    parameter logic [DW-1:0] FILL_VALUE = DW'(DEFAULT_FILL_VALUE)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic [7:0]    ioctl_index,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [DW-1:0] ioctl_dout,
    output logic          ioctl_wait,
    output logic          ram_wren,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic [AW:0]   rom_size,
    output logic [AW-1:0] rom_mask,
    output logic          busy,
    output logic          done,
    output logic          overflow
);

    localparam logic [AW:0] CAP  = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] LAST = {1'b0, {AW{1'b1}}};

    state_t        state, state_next;
    logic          dl_q;
    logic          rise, fall, start;
    logic          in_range;
    logic [AW:0]   size_cand, size_next;
    logic [AW:0]   fill_addr;
    logic [AW-1:0] mask_calc;

    pow2_mask #(.AW(AW)) u_mask (
        .size (rom_size),
        .mask (mask_calc)
    );

    always_comb begin
        rise      = ioctl_download & ~dl_q;
        fall      = ~ioctl_download & dl_q;
        start     = rise && (ioctl_index == CART_INDEX);
        in_range  = ~|ioctl_addr[24:AW];
        size_cand = in_range ? ({1'b0, ioctl_addr[AW-1:0]} + (AW+1)'(1)) : CAP;
        size_next = rom_size;
        if (state == ST_LOAD && ioctl_wr && size_cand > rom_size) begin
            size_next = size_cand;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        ioctl_wait = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                done = (state == ST_DONE);
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                busy = 1'b1;
                // a full window leaves nothing to pad, so the fill pass is skipped
                if (fall) state_next = (size_next == CAP) ? ST_MASK : ST_FILL;
            end
            ST_FILL: begin
                busy       = 1'b1;
                ioctl_wait = 1'b1;
                if (fill_addr == LAST) state_next = ST_MASK;
            end
            ST_MASK: begin
                busy       = 1'b1;
                ioctl_wait = 1'b1;
                state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dl_q      <= 1'b0;
            rom_size  <= '0;
            rom_mask  <= '1;
            overflow  <= 1'b0;
            ram_wren  <= 1'b0;
            ram_addr  <= '0;
            ram_data  <= '0;
            fill_addr <= '0;
        end else begin
            dl_q     <= ioctl_download;
            ram_wren <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        rom_size <= '0;
                        overflow <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    rom_size  <= size_next;
                    fill_addr <= size_next;
                    if (ioctl_wr) begin
                        if (in_range) begin
                            ram_wren <= 1'b1;
                            ram_addr <= ioctl_addr[AW-1:0];
                            ram_data <= ioctl_dout;
                        end else begin
                            overflow <= 1'b1;
                        end
                    end
                end
                ST_FILL: begin
                    ram_wren  <= 1'b1;
                    ram_addr  <= fill_addr[AW-1:0];
                    ram_data  <= FILL_VALUE;
                    fill_addr <= fill_addr + (AW+1)'(1);
                end
                ST_MASK: begin
                    rom_mask <= mask_calc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: a full-size instance for the 32 KiB scenarios and a
// 1 KiB instance for table-driven, randomized and falling-edge corner cases.
module tb_rom_loader;
    import rom_loader_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        dl_a = 1'b0, dl_b = 1'b0;
    logic [7:0]  index = 8'h01;
    logic        wr = 1'b0;
    logic [24:0] addr = '0;
    logic [7:0]  dout = '0;

    logic        wait_a, wren_a, busy_a, done_a, ovf_a;
    logic [14:0] addr_a, mask_a;
    logic [15:0] size_a;
    logic [7:0]  data_a;
    logic        wait_b, wren_b, busy_b, done_b, ovf_b;
    logic [9:0]  addr_b, mask_b;
    logic [10:0] size_b;
    logic [7:0]  data_b;

    always #5 clock = ~clock;

    rom_loader #(.AW(15), .DW(8), .CART_INDEX(8'h01), .FILL_VALUE(8'hFF)) dut_a (
        .clock(clock), .reset(reset), .ioctl_download(dl_a), .ioctl_index(index),
        .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wait_a),
        .ram_wren(wren_a), .ram_addr(addr_a), .ram_data(data_a), .rom_size(size_a),
        .rom_mask(mask_a), .busy(busy_a), .done(done_a), .overflow(ovf_a)
    );

    rom_loader #(.AW(10), .DW(8), .CART_INDEX(8'h01), .FILL_VALUE(8'hFF)) dut_b (
        .clock(clock), .reset(reset), .ioctl_download(dl_b), .ioctl_index(index),
        .ioctl_wr(wr), .ioctl_addr(addr), .ioctl_dout(dout), .ioctl_wait(wait_b),
        .ram_wren(wren_b), .ram_addr(addr_b), .ram_data(data_b), .rom_size(size_b),
        .rom_mask(mask_b), .busy(busy_b), .done(done_b), .overflow(ovf_b)
    );

    bit          sel = 1'b0;
    logic        m_wren, m_wait, m_busy, m_done, m_ovf;
    logic [14:0] m_addr, m_mask;
    logic [15:0] m_size;
    logic [7:0]  m_data;

    always_comb begin
        if (sel) begin
            m_wren = wren_b; m_wait = wait_b; m_busy = busy_b; m_done = done_b; m_ovf = ovf_b;
            m_addr = {5'b0, addr_b}; m_mask = {5'b0, mask_b}; m_size = {5'b0, size_b}; m_data = data_b;
        end else begin
            m_wren = wren_a; m_wait = wait_a; m_busy = busy_a; m_done = done_a; m_ovf = ovf_a;
            m_addr = addr_a; m_mask = mask_a; m_size = size_a; m_data = data_a;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed { logic [14:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic [24:0] addr; logic [7:0] data; } byte_t;

    wr_t   log_q[$];
    byte_t offer_q[$];
    int    wait_cnt = 0;
    int    busy_cnt = 0;

    always @(negedge clock) begin
        if (m_wren) log_q.push_back(wr_t'({m_addr, m_data}));
        if (m_wait) wait_cnt++;
        if (m_busy) busy_cnt++;
    end

    function automatic int cap_of();
        return sel ? 1024 : 32768;
    endfunction

    task automatic set_dl(input logic v);
        if (sel) dl_b = v; else dl_a = v;
    endtask

    // Stream offer_q with a matching index and check each byte's write one cycle later.
    task automatic start_load(input string tag, input bit coinc);
        int lat_err = 0;
        int n = offer_q.size();
        log_q.delete();
        wait_cnt = 0;
        @(posedge clock); #1;
        index = 8'h01;
        set_dl(1'b1);
        for (int i = 0; i <= n; i++) begin
            @(posedge clock); #1;
            if (i < n) begin
                wr = 1'b1; addr = offer_q[i].addr; dout = offer_q[i].data;
                if (coinc && i == n - 1) set_dl(1'b0);
            end else begin
                wr = 1'b0;
                set_dl(1'b0);
            end
            @(negedge clock);
            if (i == 0) check({tag, " load entry busy/done"}, {30'b0, m_busy, m_done}, 32'b10);
            if (i > 0) begin
                if (int'(offer_q[i-1].addr) < cap_of()) begin
                    if (!(m_wren && m_addr == offer_q[i-1].addr[14:0] && m_data == offer_q[i-1].data))
                        lat_err++;
                end else if (m_wren) begin
                    lat_err++;
                end
            end
        end
        check({tag, " load write latency errors"}, lat_err, 0);
    endtask

    // Reference: in-range bytes in order, then fill of the untouched tail.
    task automatic finish_load(input string tag);
        int  cap = cap_of();
        int  size = 0;
        bit  ovf = 1'b0;
        int  p = 1;
        int  mask;
        int  t = 0;
        int  err = 0;
        wr_t exp_q[$];
        foreach (offer_q[i]) begin
            if (int'(offer_q[i].addr) >= cap) begin
                ovf = 1'b1;
                if (cap > size) size = cap;
            end else begin
                exp_q.push_back(wr_t'({offer_q[i].addr[14:0], offer_q[i].data}));
                if (int'(offer_q[i].addr) + 1 > size) size = int'(offer_q[i].addr) + 1;
            end
        end
        for (int a = size; a < cap; a++) exp_q.push_back(wr_t'({15'(a), 8'hFF}));
        while (p < size) p = p * 2;
        mask = (size <= 1) ? 0 : p - 1;

        while (!m_done && t < cap + 64) begin
            @(negedge clock);
            t++;
        end
        check({tag, " done"}, m_done, 1);
        check({tag, " write count"}, log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            if (log_q[i] != exp_q[i]) err++;
        check({tag, " write content errors"}, err, 0);
        check({tag, " rom_size"}, m_size, size);
        check({tag, " rom_mask"}, m_mask, mask);
        check({tag, " overflow"}, m_ovf, ovf);
        check({tag, " busy"}, m_busy, 0);
        check({tag, " wait cycles"}, wait_cnt, cap - size + 1);
    endtask

    typedef struct {
        logic [24:0] addr;
        bit          empty;
        logic [10:0] size;
        logic [9:0]  mask;
        bit          ovf;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{25'd0,    1'b0, 11'd1,    10'h000, 1'b0};
        tbl[1] = '{25'd1,    1'b0, 11'd2,    10'h001, 1'b0};
        tbl[2] = '{25'd2,    1'b0, 11'd3,    10'h003, 1'b0};
        tbl[3] = '{25'd63,   1'b0, 11'd64,   10'h03F, 1'b0};
        tbl[4] = '{25'd64,   1'b0, 11'd65,   10'h07F, 1'b0};
        tbl[5] = '{25'd511,  1'b0, 11'd512,  10'h1FF, 1'b0};
        tbl[6] = '{25'd512,  1'b0, 11'd513,  10'h3FF, 1'b0};
        tbl[7] = '{25'd1023, 1'b0, 11'd1024, 10'h3FF, 1'b0};
        tbl[8] = '{25'd1024, 1'b0, 11'd1024, 10'h3FF, 1'b1};
        tbl[9] = '{25'd0,    1'b1, 11'd0,    10'h000, 1'b0};

        #12;
        check("reset A flags", {27'b0, wren_a, wait_a, busy_a, done_a, ovf_a}, 0);
        check("reset A rom_size", size_a, 0);
        check("reset A rom_mask", mask_a, 15'h7FFF);
        check("reset A ram addr/data", {addr_a, data_a}, 0);
        check("reset B flags", {27'b0, wren_b, wait_b, busy_b, done_b, ovf_b}, 0);
        check("reset B rom_mask", mask_b, 10'h3FF);
        @(posedge clock); #1;
        reset = 1'b0;

        // 8 KiB incrementing image, padded to 32 KiB
        sel = 1'b0;
        offer_q.delete();
        for (int i = 0; i < 8192; i++) offer_q.push_back(byte_t'({25'(i), 8'(i)}));
        start_load("8k", 1'b0);
        finish_load("8k");

        // full window: no fill, one MASK cycle of wait
        offer_q.delete();
        for (int i = 0; i < 32768; i++) offer_q.push_back(byte_t'({25'(i), 8'(i * 7 + 3)}));
        start_load("32k", 1'b0);
        finish_load("32k");

        // byte just past the window
        offer_q.delete();
        offer_q.push_back(byte_t'({25'd32768, 8'hA5}));
        start_load("ovf", 1'b0);
        finish_load("ovf");

        // non-matching index from DONE is ignored
        log_q.delete();
        busy_cnt = 0;
        @(posedge clock); #1;
        index = 8'h00; dl_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            wr = 1'b1; addr = 25'(i); dout = 8'(i);
        end
        @(posedge clock); #1;
        wr = 1'b0; dl_a = 1'b0;
        repeat (4) @(negedge clock);
        check("bad index writes", log_q.size(), 0);
        check("bad index busy cycles", busy_cnt, 0);
        check("bad index done", m_done, 1);
        check("bad index rom_size", m_size, 32768);
        check("bad index overflow", m_ovf, 1);
        index = 8'h01;

        // reset in the middle of the fill pass
        offer_q.delete();
        offer_q.push_back(byte_t'({25'd19990, 8'h5A}));
        start_load("rst", 1'b0);
        begin
            int t = 0;
            while (!(m_wren && m_addr == 15'd20000) && t < 1000) begin
                @(negedge clock);
                t++;
            end
        end
        check("rst reached fill 20000", {31'b0, m_wren && m_addr == 15'd20000}, 1);
        #1 reset = 1'b1;
        #1;
        check("rst flags", {27'b0, wren_a, wait_a, busy_a, done_a, ovf_a}, 0);
        check("rst rom_size/mask", {size_a, 1'b0, mask_a}, {16'd0, 1'b0, 15'h7FFF});
        log_q.delete();
        busy_cnt = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (10) @(negedge clock);
        check("rst writes after reset", log_q.size(), 0);
        check("rst busy after release", busy_cnt, 0);
        check("rst done after release", m_done, 0);
        offer_q.delete();
        offer_q.push_back(byte_t'({25'd32767, 8'hC3}));
        start_load("restart", 1'b0);
        finish_load("restart");

        // small instance: single-byte table
        sel = 1'b1;
        for (int k = 0; k < 10; k++) begin
            offer_q.delete();
            if (!tbl[k].empty) offer_q.push_back(byte_t'({tbl[k].addr, 8'(k + 8'h40)}));
            start_load($sformatf("tbl%0d", k), 1'b0);
            finish_load($sformatf("tbl%0d", k));
            check($sformatf("tbl%0d size", k), m_size, {5'b0, tbl[k].size});
            check($sformatf("tbl%0d mask", k), m_mask, {5'b0, tbl[k].mask});
            check($sformatf("tbl%0d ovf", k), m_ovf, tbl[k].ovf);
        end

        // randomized out-of-order loads, some past the window
        for (int r = 0; r < 4; r++) begin
            int n = $urandom_range(1, 40);
            offer_q.delete();
            for (int i = 0; i < n; i++)
                offer_q.push_back(byte_t'({25'($urandom_range(0, 1100)), 8'($urandom)}));
            start_load($sformatf("rand%0d", r), 1'($urandom_range(0, 1)));
            finish_load($sformatf("rand%0d", r));
        end

        // last byte coincident with the falling download edge
        offer_q.delete();
        for (int i = 96; i <= 100; i++) offer_q.push_back(byte_t'({25'(i), 8'(i)}));
        start_load("fall", 1'b1);
        finish_load("fall");
        check("fall rom_size", m_size, 101);
        check("fall rom_mask", m_mask, 15'h007F);
        check("fall first fill addr", (log_q.size() > 5) ? {17'b0, log_q[5].addr} : 32'hFFFF, 101);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
